// File: rtl/serial_parity_unit_pkg.sv
// Shared types and constants for the serial parity unit.
package serial_parity_unit_pkg;

    // Word sequencing states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Mode encodings sampled on an accepted start.
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage : serial_parity_unit_pkg

// File: rtl/serial_parity_unit_xor_accumulator.sv
// One-bit XOR accumulator: loads INIT on clear, folds bit_in in when enabled.
module xor_accumulator #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_d;
    logic acc_q;

    // Next accumulator value: clear has priority over the XOR fold.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = INIT;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register, reset to the parity seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= INIT;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule : xor_accumulator

// File: rtl/serial_parity_unit.sv
// Serial parity generator/checker: folds WORD_LEN bits through an XOR
// accumulator and reports parity (generate) or a parity mismatch (check).
module serial_parity_unit
    import serial_parity_unit_pkg::*;
#(
    parameter int unsigned WORD_LEN = 8,
    parameter int unsigned ODD      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode,
    input  logic                            bit_in,
    input  logic                            bit_valid,
    output logic                            busy,
    output logic                            parity_out,
    output logic                            parity_valid,
    output logic                            error,
    output logic [$clog2(WORD_LEN+1)-1:0]   bit_count
);

    localparam int   CW      = $clog2(WORD_LEN + 1);
    localparam logic ODD_BIT = ODD[0];

    state_t          state_d, state_q;
    logic [CW-1:0]   bit_count_d, bit_count_q;
    logic            mode_d, mode_q;
    logic            busy_d, busy_q;
    logic            parity_out_d, parity_out_q;
    logic            parity_valid_d, parity_valid_q;
    logic            error_d, error_q;
    logic            acc_clr_s;
    logic            acc_en_s;
    logic            acc_s;
    logic            last_bit_s;

    xor_accumulator #(
        .INIT (ODD_BIT)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr_s),
        .en     (acc_en_s),
        .bit_in (bit_in),
        .acc    (acc_s)
    );

    assign last_bit_s = (bit_count_q == CW'(WORD_LEN - 1));

    // Next-state, counter and output-register logic for the word sequencer.
    always_comb begin
        state_d        = state_q;
        bit_count_d    = bit_count_q;
        mode_d         = mode_q;
        parity_out_d   = parity_out_q;
        error_d        = error_q;
        parity_valid_d = 1'b0;
        acc_clr_s      = 1'b0;
        acc_en_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SHIFT;
                    acc_clr_s    = 1'b1;
                    bit_count_d  = '0;
                    mode_d       = mode;
                    parity_out_d = 1'b0;
                    error_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    acc_en_s = 1'b1;
                    if (bit_count_q != CW'(WORD_LEN)) begin
                        bit_count_d = bit_count_q + CW'(1);
                    end else begin
                        bit_count_d = bit_count_q;
                    end
                    if (last_bit_s) begin
                        if (mode_q == MODE_CHK) begin
                            state_d = PARITY;
                        end else begin
                            // Result registers see the value the accumulator takes this edge.
                            state_d        = REPORT;
                            parity_valid_d = 1'b1;
                            parity_out_d   = acc_s ^ bit_in;
                            error_d        = 1'b0;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    state_d        = REPORT;
                    parity_valid_d = 1'b1;
                    parity_out_d   = acc_s;
                    error_d        = acc_s ^ bit_in;
                end else begin
                    state_d = PARITY;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_count_q    <= '0;
            mode_q         <= MODE_GEN;
            busy_q         <= 1'b0;
            parity_out_q   <= 1'b0;
            parity_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_count_q    <= bit_count_d;
            mode_q         <= mode_d;
            busy_q         <= busy_d;
            parity_out_q   <= parity_out_d;
            parity_valid_q <= parity_valid_d;
            error_q        <= error_d;
        end
    end

    assign busy         = busy_q;
    assign parity_out   = parity_out_q;
    assign parity_valid = parity_valid_q;
    assign error        = error_q;
    assign bit_count    = bit_count_q;

endmodule : serial_parity_unit

// File: tb/tb_serial_parity_unit.sv
// Directed bench for serial_parity_unit: an even (ODD=0) and an odd (ODD=1)
// instance share stimulus; expected results go through a scoreboard queue.
module tb_serial_parity_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic       bit_in;
    logic       bit_valid;

    logic       busy0, pout0, pv0, err0;
    logic       busy1, pout1, pv1, err1;
    logic [3:0] bc0, bc1;

    typedef struct {
        logic p0;
        logic p1;
        logic e0;
        logic e1;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fail_cnt  = 0;

    serial_parity_unit #(.WORD_LEN(8), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .busy(busy0), .parity_out(pout0),
        .parity_valid(pv0), .error(err0), .bit_count(bc0)
    );

    serial_parity_unit #(.WORD_LEN(8), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .busy(busy1), .parity_out(pout1),
        .parity_valid(pv1), .error(err1), .bit_count(bc1)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic m, input logic [7:0] bits, input logic pbit);
        exp_t e;
        logic a0;
        a0   = ^bits;
        e.p0 = a0;
        e.p1 = ~a0;
        e.e0 = m ? (a0 ^ pbit) : 1'b0;
        e.e1 = m ? ((~a0) ^ pbit) : 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   lat;
        e   = sb_q.pop_front();
        lat = 0;
        while (pv0 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk_cnt({tag, "_latency"}, lat, 0);
        chk_bit({tag, "_valid_odd"}, pv1, 1'b1);
        chk_bit({tag, "_parity_even"}, pout0, e.p0);
        chk_bit({tag, "_parity_odd"}, pout1, e.p1);
        chk_bit({tag, "_error_even"}, err0, e.e0);
        chk_bit({tag, "_error_odd"}, err1, e.e1);
        tick();
        chk_bit({tag, "_strobe_drop"}, pv0, 1'b0);
        chk_bit({tag, "_busy_drop"}, busy0, 1'b0);
        chk_bit({tag, "_parity_hold"}, pout0, e.p0);
    endtask

    task automatic run_word(input string tag, input logic m, input logic [7:0] bits,
                            input logic pbit, input int gap_at, input int gap_len,
                            input bit start_mid);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = ~m;
        chk_bit({tag, "_busy"}, busy0, 1'b1);
        chk_cnt({tag, "_count0"}, int'(bc0), 0);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'b1;
                    start     = start_mid && (g == 1);
                    tick();
                    start = 1'b0;
                    chk_cnt({tag, "_gap_count"}, int'(bc0), i);
                end
            end
            bit_in    = bits[i];
            bit_valid = 1'b1;
            if (i == 7 && m == 1'b0) push_exp(m, bits, pbit);
            tick();
            bit_valid = 1'b0;
            chk_cnt({tag, "_count"}, int'(bc1), i + 1);
        end
        if (m) begin
            bit_in    = pbit;
            bit_valid = 1'b1;
            push_exp(m, bits, pbit);
            tick();
            bit_valid = 1'b0;
        end
        wait_result(tag);
    endtask

    // Linear directed test sequence.
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        #1;
        chk_bit("reset_busy", busy0, 1'b0);
        chk_bit("reset_valid", pv0, 1'b0);
        chk_bit("reset_parity", pout1, 1'b0);
        chk_bit("reset_error", err0, 1'b0);
        chk_cnt("reset_count", int'(bc0), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Generate mode, bits 1,0,1,1,0,0,1,0 (first bit in LSB).
        run_word("gen", 1'b0, 8'h4D, 1'b0, -1, 0, 1'b0);
        // Check mode, three ones, good then bad received parity.
        run_word("chk_ok", 1'b1, 8'h07, 1'b1, -1, 0, 1'b0);
        run_word("chk_bad", 1'b1, 8'h07, 1'b0, -1, 0, 1'b0);
        // Gap of 3 cycles between bits 4 and 5, start pulsed in the gap.
        run_word("gen_gap", 1'b0, 8'h4D, 1'b0, 4, 3, 1'b1);

        // Asynchronous reset after five bits of a word.
        start = 1'b1;
        mode  = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        chk_cnt("pre_rst_count", int'(bc0), 5);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("async_rst_busy", busy0, 1'b0);
        chk_bit("async_rst_valid", pv0, 1'b0);
        chk_cnt("async_rst_count", int'(bc0), 0);
        #2;
        rst = 1'b0;
        tick();
        run_word("after_rst", 1'b0, 8'hFF, 1'b0, -1, 0, 1'b0);

        // bit_valid pulses in IDLE without start.
        for (int i = 0; i < 4; i++) begin
            bit_in    = i[0];
            bit_valid = 1'b1;
            tick();
            chk_bit("idle_busy", busy0, 1'b0);
            chk_bit("idle_valid", pv1, 1'b0);
            chk_cnt("idle_count", int'(bc0), 8);
        end
        bit_valid = 1'b0;
        tick();

        chk_cnt("scoreboard_empty", int'(sb_q.size()), 0);
        if (fail_cnt != 0) $display("checks with errors: %0d", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_serial_parity_unit
